// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types, constants and helpers for the RAT seven-segment peripheral.
// Holds the conversion FSM state enum, the BCD digit bundle, the segment decode table
// and the double-dabble nibble adjust used by bin2bcd8.
package sseg_pkg;

  // Conversion FSM states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  // Output port address the wrapper decodes to generate DATA_LD
  localparam logic [7:0] SSEG_ID   = 8'h81;

  // All segments and dp off (active low)
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Three BCD digits of an 8-bit value (hundreds is at most 2)
  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd3_t;

  // Digit -> {dp,g,f,e,d,c,b,a}, active low, dp always off.
  // Codes 10..15 never come out of a correct conversion; show them as blank.
  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 so the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
    logic [11:0] adj;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Purpose: sequential double-dabble, 8-bit binary -> 3 BCD digits, one shift per clock.
// Latency: strobe sampled at E0, BUSY high E0..E8, digits updates atomically at E8.
// Backpressure: none; DATA_LD always accepted, a strobe mid-conversion restarts (last write wins).
import sseg_pkg::*;

module bin2bcd8 (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_LD,
  output logic       BUSY,
  output bcd3_t      digits
);

  conv_state_t state;
  logic [7:0]  bin_r;
  logic [11:0] bcd_r;
  logic [2:0]  cnt;
  logic        busy_r;
  bcd3_t       digits_r;

  logic [11:0] bcd_adj;
  logic [19:0] shifted;
  logic [11:0] bcd_next;
  logic [7:0]  bin_next;

  // Adjust-then-shift datapath for one double-dabble step.
  // The adjusted top bit is always 0 for 8-bit inputs, so dropping it is exact.
  always_comb begin
    bcd_adj  = dabble_adjust(bcd_r);
    shifted  = {bcd_adj[10:0], bin_r, 1'b0};
    bcd_next = shifted[19:8];
    bin_next = shifted[7:0];
  end

  // Conversion FSM: load on strobe (restarting any conversion), shift 8 times,
  // publish the result only on the eighth shift so the display never sees partial digits.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      bin_r    <= '0;
      bcd_r    <= '0;
      cnt      <= '0;
      busy_r   <= 1'b0;
      digits_r <= '0;
    end else if (DATA_LD) begin
      // A strobe beats the finishing edge: the old result is discarded.
      state    <= CONV;
      bin_r    <= DATA_IN;
      bcd_r    <= '0;
      cnt      <= '0;
      busy_r   <= 1'b1;
    end else if (state == CONV) begin
      bin_r <= bin_next;
      bcd_r <= bcd_next;
      cnt   <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        digits_r <= bcd3_t'(bcd_next);
        busy_r   <= 1'b0;
        state    <= IDLE;
      end
    end
  end

  assign BUSY   = busy_r;
  assign digits = digits_r;

endmodule

// File: rtl/sseg_display.sv
// Purpose: RAT output-port peripheral; converts the byte written to SSEG_ID and scans it onto a 4-digit CA display.
// Latency: BUSY high 8 cycles after DATA_LD; ANODES/SEGMENTS registered one cycle after scan index; SSEG_BLANK_LZ_EN enables leading-zero blanking.
// Backpressure: none; every DATA_LD is accepted and a new one restarts the conversion.
import sseg_pkg::*;

module sseg_display #(
  parameter int REFRESH_DIV = 50_000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_LD,
  output logic       BUSY,
  output logic [7:0] SEGMENTS,
  output logic [3:0] ANODES
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  bcd3_t         digits;
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    scan_idx;
  logic          hund_blank;
  logic          tens_blank;
  logic [7:0]    seg_nxt;
  logic [3:0]    an_nxt;

  bin2bcd8 u_bin2bcd8 (
    .CLK     (CLK),
    .reset   (reset),
    .DATA_IN (DATA_IN),
    .DATA_LD (DATA_LD),
    .BUSY    (BUSY),
    .digits  (digits)
  );

  // Refresh divider and scan index: each digit slot lasts REFRESH_DIV cycles.
  always_ff @(posedge CLK) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= 2'd0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Leading-zero blanking is a display-time decision; the stored digits are untouched.
`ifdef SSEG_BLANK_LZ_EN
  assign hund_blank = (digits.hund == 4'd0);
  assign tens_blank = hund_blank && (digits.tens == 4'd0);
`else
  assign hund_blank = 1'b0;
  assign tens_blank = 1'b0;
`endif

  // Select and decode the digit for the current slot; slot 3 is always dark.
  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = ~(4'b0001 << scan_idx);
    case (scan_idx)
      2'd0:    seg_nxt = seg_decode(digits.ones);
      2'd1:    seg_nxt = tens_blank ? SEG_BLANK : seg_decode(digits.tens);
      2'd2:    seg_nxt = hund_blank ? SEG_BLANK : seg_decode(digits.hund);
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  // Output registers: glitch-free pins, all digits off during reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      SEGMENTS <= SEG_BLANK;
      ANODES   <= 4'b1111;
    end else begin
      SEGMENTS <= seg_nxt;
      ANODES   <= an_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_display.sv
// Bench for sseg_display with a short refresh period; expected digits come from
// decimal arithmetic on the loaded value and a segment lookup table.
module tb_sseg_display;

  localparam int DIV = 4;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] DATA_IN;
  logic       DATA_LD;
  logic       BUSY;
  logic [7:0] SEGMENTS;
  logic [3:0] ANODES;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] seg_tab [10];

  sseg_display #(.REFRESH_DIV(DIV)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .DATA_IN  (DATA_IN),
    .DATA_LD  (DATA_LD),
    .BUSY     (BUSY),
    .SEGMENTS (SEGMENTS),
    .ANODES   (ANODES)
  );

  always #5 CLK = ~CLK;

  // Expected segment pattern for slot (0=ones,1=tens,2=hundreds,3=unused) of value v
  function automatic logic [7:0] model_seg(input int v, input int slot);
    int o, t, h;
    o = v % 10;
    t = (v / 10) % 10;
    h = v / 100;
    case (slot)
      0: return seg_tab[o];
      1: begin
`ifdef SSEG_BLANK_LZ_EN
        if (h == 0 && t == 0) return 8'hFF;
`endif
        return seg_tab[t];
      end
      2: begin
`ifdef SSEG_BLANK_LZ_EN
        if (h == 0) return 8'hFF;
`endif
        return seg_tab[h];
      end
      default: return 8'hFF;
    endcase
  endfunction

  // Pulse DATA_LD for one cycle; called and returns on a falling edge
  task automatic strobe(input logic [7:0] v);
    DATA_IN = v;
    DATA_LD = 1'b1;
    @(negedge CLK);
    DATA_LD = 1'b0;
  endtask

  // Count cycles BUSY stays high (bounded), noting any appearance of a "7"
  task automatic count_busy(output int n, output bit saw_f8);
    n = 0;
    saw_f8 = 1'b0;
    while (BUSY === 1'b1 && n < 50) begin
      n++;
      if (SEGMENTS === 8'hF8) saw_f8 = 1'b1;
      @(negedge CLK);
    end
  endtask

  // Observe three scan frames, keeping the last pattern seen per anode
  task automatic capture_frame(output logic [31:0] frame, output bit saw_f8);
    frame  = 'x;
    saw_f8 = 1'b0;
    for (int i = 0; i < 3 * 4 * DIV; i++) begin
      case (ANODES)
        4'b1110: frame[7:0]   = SEGMENTS;
        4'b1101: frame[15:8]  = SEGMENTS;
        4'b1011: frame[23:16] = SEGMENTS;
        4'b0111: frame[31:24] = SEGMENTS;
        default: ;
      endcase
      if (SEGMENTS === 8'hF8) saw_f8 = 1'b1;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    DATA_LD = 1'b0;
    DATA_IN = 8'h00;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (ANODES !== 4'b1111) begin n_fail++; $display("FAIL reset_anodes: got %b expected 1111", ANODES); end
    n_checks++;
    if (SEGMENTS !== 8'hFF) begin n_fail++; $display("FAIL reset_segments: got %h expected ff", SEGMENTS); end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    reset = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ANODES !== 4'b1110) begin n_fail++; $display("FAIL post_reset_anodes: got %b expected 1110", ANODES); end
    n_checks++;
    if (SEGMENTS !== 8'hC0) begin n_fail++; $display("FAIL post_reset_segments: got %h expected c0", SEGMENTS); end
  endtask

  task automatic test_max_value();
    int n; bit s7; logic [31:0] fr;
    strobe(8'hFF);
    count_busy(n, s7);
    n_checks++;
    if (n != 8) begin n_fail++; $display("FAIL max_busy_len: got %0d expected 8", n); end
    capture_frame(fr, s7);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fr[8*i +: 8] !== model_seg(255, i)) begin
        n_fail++; $display("FAIL max_slot%0d: got %h expected %h", i, fr[8*i +: 8], model_seg(255, i));
      end
    end
  endtask

  // Second strobe lands gap cycles after the first; the first value must never show
  task automatic test_restart(input string nm, input logic [7:0] a, input logic [7:0] b, input int gap);
    int n; bit s7a, s7b, s7c; logic [31:0] fr;
    s7a = 1'b0;
    strobe(a);
    for (int i = 0; i < gap - 1; i++) begin
      if (SEGMENTS === 8'hF8) s7a = 1'b1;
      @(negedge CLK);
    end
    strobe(b);
    count_busy(n, s7b);
    n_checks++;
    if (n != 8) begin n_fail++; $display("FAIL %s_busy_len: got %0d expected 8", nm, n); end
    capture_frame(fr, s7c);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fr[8*i +: 8] !== model_seg(int'(b), i)) begin
        n_fail++; $display("FAIL %s_slot%0d: got %h expected %h", nm, i, fr[8*i +: 8], model_seg(int'(b), i));
      end
    end
    n_checks++;
    if ((s7a | s7b | s7c) !== 1'b0) begin n_fail++; $display("FAIL %s_stale_digit: got 7 shown expected never", nm); end
  endtask

  task automatic test_zero();
    int n; bit s7; logic [31:0] fr;
    strobe(8'h00);
    count_busy(n, s7);
    n_checks++;
    if (n != 8) begin n_fail++; $display("FAIL zero_busy_len: got %0d expected 8", n); end
    capture_frame(fr, s7);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fr[8*i +: 8] !== model_seg(0, i)) begin
        n_fail++; $display("FAIL zero_slot%0d: got %h expected %h", i, fr[8*i +: 8], model_seg(0, i));
      end
    end
  endtask

  task automatic test_scan_timing();
    logic [3:0] start, pat, exp_pat, one;
    int wait_n, len, k0;
    one = 4'b0001;
    start = ANODES;
    wait_n = 0;
    while (ANODES === start && wait_n < 20) begin wait_n++; @(negedge CLK); end
    n_checks++;
    if (ANODES === start) begin n_fail++; $display("FAIL scan_advance: got %b stuck expected change", ANODES); end
    k0 = 0;
    for (int k = 0; k < 4; k++) if (ANODES === ~(one << k)) k0 = k;
    for (int r = 0; r < 8; r++) begin
      exp_pat = ~(one << ((k0 + r) % 4));
      pat = ANODES;
      n_checks++;
      if (pat !== exp_pat) begin n_fail++; $display("FAIL scan_order%0d: got %b expected %b", r, pat, exp_pat); end
      len = 0;
      while (ANODES === pat && len < 20) begin len++; @(negedge CLK); end
      n_checks++;
      if (len != DIV) begin n_fail++; $display("FAIL scan_len%0d: got %0d expected %0d", r, len, DIV); end
    end
  endtask

  task automatic test_random();
    int n; bit s7; logic [31:0] fr; logic [7:0] a, v; int gap;
    for (int it = 0; it < 24; it++) begin
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        a   = 8'($urandom_range(0, 255));
        gap = $urandom_range(1, 9);
        strobe(a);
        for (int i = 0; i < gap - 1; i++) @(negedge CLK);
      end
      strobe(v);
      count_busy(n, s7);
      n_checks++;
      if (n != 8) begin n_fail++; $display("FAIL rand%0d_busy_len: got %0d expected 8", it, n); end
      capture_frame(fr, s7);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (fr[8*i +: 8] !== model_seg(int'(v), i)) begin
          n_fail++; $display("FAIL rand%0d_v%0d_slot%0d: got %h expected %h", it, v, i, fr[8*i +: 8], model_seg(int'(v), i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    bit busy_seen; bit s7; logic [31:0] fr;
    strobe(8'h2A);
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", BUSY); end
    busy_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (BUSY !== 1'b0) busy_seen = 1'b1;
      @(negedge CLK);
    end
    n_checks++;
    if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_later: got 1 expected 0"); end
    capture_frame(fr, s7);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fr[8*i +: 8] !== model_seg(0, i)) begin
        n_fail++; $display("FAIL midreset_slot%0d: got %h expected %h", i, fr[8*i +: 8], model_seg(0, i));
      end
    end
  endtask

  initial begin
    seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
    seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
    seg_tab[8] = 8'h80; seg_tab[9] = 8'h90;
    reset   = 1'b1;
    DATA_LD = 1'b0;
    DATA_IN = 8'h00;

    test_reset();
    test_max_value();
    test_restart("restart", 8'h07, 8'h64, 3);
    test_restart("finish_edge", 8'h07, 8'hC8, 8);
    test_zero();
    test_scan_timing();
    test_random();
    test_reset_mid_conv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
